// File: rtl/pit_timer0_if.sv
// Word bus between the CPU-side decoder and the PIT (shared with the interrupt controller).
// The master drives select/strobes; the timer answers with a registered ack and read data.
interface pit_timer0_if;
    logic        cs;
    logic        data_m_addr;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic [1:0]  data_m_bytesel;
    logic        data_m_wr_en;
    logic        data_m_access;
    logic        data_m_ack;

    modport master (
        output cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
        input  data_m_data_out, data_m_ack
    );
    modport slave (
        input  cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
        output data_m_data_out, data_m_ack
    );
endinterface

// File: rtl/pit_timer0.sv
// 8254-style interval timer, counter 0 only: binary modes 0/2/3 on a one-cycle pit_clk_en tick.
// OUT (intr_out) feeds the edge-triggered interrupt controller as IRQ0.
module pit_timer0 #(
    parameter logic [15:0] DEFAULT_RELOAD = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    pit_timer0_if.slave bus,
    input  logic        pit_clk_en,
    output logic        intr_out
);
    typedef enum logic [1:0] {MODE0 = 2'd0, MODE2 = 2'd2, MODE3 = 2'd3} mode_e;
    localparam logic [1:0] RW_LATCH = 2'b00, RW_LSB = 2'b01, RW_MSB = 2'b10;

    mode_e       mode_q, mode_d, ctl_mode;
    logic [1:0]  rw_q, rw_d;
    logic [15:0] reload_q, reload_d, latched_q, latched_d, data_out_q, data_out_d;
    logic [16:0] count_q, count_d;
    logic        load_pending_q, load_pending_d, armed_q, armed_d, intr_q, intr_d;
    logic        latch_vld_q, latch_vld_d, wr_tog_q, wr_tog_d, rd_tog_q, rd_tog_d, ack_q, ack_d;

    logic        acc, wr, rd, data_wr, ctl_wr, latch_cmd, ctr0_rd, tick;
    logic [7:0]  wb, rbyte;
    logic [6:0]  ctl;   // control byte minus the ignored BCD bit
    logic [15:0] rsrc;
    logic [16:0] n_eff, n_hi, n_lo, dec1, dec2;
    logic        done, first_byte, last_rd;

    always_comb begin
        acc       = bus.cs & bus.data_m_access;
        wr        = acc & bus.data_m_wr_en;
        rd        = acc & ~bus.data_m_wr_en;
        wb        = bus.data_m_data_in[7:0];
        ctl       = bus.data_m_data_in[15:9];
        data_wr   = wr & ~bus.data_m_addr & bus.data_m_bytesel[0];
        ctl_wr    = wr & bus.data_m_addr & bus.data_m_bytesel[1] & (ctl[6:5] == 2'b00);
        latch_cmd = ctl_wr & (ctl[4:3] == RW_LATCH);
        ctr0_rd   = rd & ~bus.data_m_addr & bus.data_m_bytesel[0];
        // a mode-setting control write swallows a coincident tick
        tick      = pit_clk_en & ~(ctl_wr & ~latch_cmd);
        case (ctl[2:0])
            3'd2, 3'd6: ctl_mode = MODE2;
            3'd3, 3'd7: ctl_mode = MODE3;
            default:    ctl_mode = MODE0;
        endcase
        n_eff = (reload_q == 16'd0) ? 17'h10000 : {1'b0, reload_q};
        if (mode_q != MODE0 && reload_q == 16'd1) n_eff = 17'd2;
        n_hi = n_eff + {16'd0, n_eff[0]};
        n_lo = {n_eff[16:1], 1'b0};
        dec1 = count_q - 17'd1;
        dec2 = count_q - 17'd2;
    end

    always_comb begin
        mode_d         = mode_q;
        rw_d           = rw_q;
        reload_d       = reload_q;
        latched_d      = latched_q;
        count_d        = count_q;
        load_pending_d = load_pending_q;
        armed_d        = armed_q;
        intr_d         = intr_q;
        latch_vld_d    = latch_vld_q;
        wr_tog_d       = wr_tog_q;
        rd_tog_d       = rd_tog_q;
        ack_d          = acc;
        data_out_d     = 16'h0000;
        done           = 1'b0;
        first_byte     = 1'b0;
        last_rd        = 1'b0;
        rsrc           = 16'h0000;
        rbyte          = 8'h00;

        // tick acts on pre-write state; bus writes below override it
        if (tick) begin
            if (load_pending_q) begin
                count_d        = (mode_q == MODE3) ? n_hi : n_eff;
                armed_d        = 1'b1;
                load_pending_d = 1'b0;
                if (mode_q != MODE0) intr_d = 1'b1;
            end else if (armed_q) begin
                case (mode_q)
                    MODE0: begin
                        count_d = {1'b0, dec1[15:0]};
                        if (count_q == 17'd1) intr_d = 1'b1;
                    end
                    MODE2: begin
                        if (count_q == 17'd1) begin
                            count_d = n_eff;
                            intr_d  = 1'b1;
                        end else begin
                            count_d = dec1;
                            if (dec1 == 17'd1) intr_d = 1'b0;
                        end
                    end
                    default: begin
                        if (count_q <= 17'd2) begin
                            intr_d  = ~intr_q;
                            count_d = intr_q ? n_lo : n_hi;
                        end else begin
                            count_d = dec2;
                        end
                    end
                endcase
            end
        end

        if (latch_cmd) begin
            if (!latch_vld_q) begin
                latched_d   = count_q[15:0];
                latch_vld_d = 1'b1;
            end
        end else if (ctl_wr) begin
            rw_d           = ctl[4:3];
            mode_d         = ctl_mode;
            wr_tog_d       = 1'b0;
            rd_tog_d       = 1'b0;
            latch_vld_d    = 1'b0;
            armed_d        = 1'b0;
            load_pending_d = 1'b0;
            intr_d         = (ctl_mode != MODE0);
        end

        if (data_wr) begin
            first_byte = 1'b1;
            case (rw_q)
                RW_LSB: begin reload_d = {8'h00, wb}; done = 1'b1; end
                RW_MSB: begin reload_d = {wb, 8'h00}; done = 1'b1; end
                default: begin
                    if (!wr_tog_q) begin
                        reload_d[7:0] = wb;
                        wr_tog_d      = 1'b1;
                    end else begin
                        reload_d[15:8] = wb;
                        wr_tog_d       = 1'b0;
                        done           = 1'b1;
                        first_byte     = 1'b0;
                    end
                end
            endcase
            if (done) load_pending_d = 1'b1;
            if (mode_q == MODE0 && first_byte) begin
                armed_d = 1'b0;
                intr_d  = 1'b0;
            end
        end

        if (ctr0_rd) begin
            rsrc = latch_vld_q ? latched_q : count_q[15:0];
            case (rw_q)
                RW_LSB: begin rbyte = rsrc[7:0];  last_rd = 1'b1; end
                RW_MSB: begin rbyte = rsrc[15:8]; last_rd = 1'b1; end
                default: begin
                    rbyte    = rd_tog_q ? rsrc[15:8] : rsrc[7:0];
                    last_rd  = rd_tog_q;
                    rd_tog_d = ~rd_tog_q;
                end
            endcase
            data_out_d = {8'h00, rbyte};
            if (last_rd) latch_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q         <= MODE3;
            rw_q           <= 2'b11;
            reload_q       <= DEFAULT_RELOAD;
            latched_q      <= 16'h0000;
            count_q        <= 17'd0;
            load_pending_q <= 1'b1;
            armed_q        <= 1'b0;
            intr_q         <= 1'b1;
            latch_vld_q    <= 1'b0;
            wr_tog_q       <= 1'b0;
            rd_tog_q       <= 1'b0;
            ack_q          <= 1'b0;
            data_out_q     <= 16'h0000;
        end else begin
            mode_q         <= mode_d;
            rw_q           <= rw_d;
            reload_q       <= reload_d;
            latched_q      <= latched_d;
            count_q        <= count_d;
            load_pending_q <= load_pending_d;
            armed_q        <= armed_d;
            intr_q         <= intr_d;
            latch_vld_q    <= latch_vld_d;
            wr_tog_q       <= wr_tog_d;
            rd_tog_q       <= rd_tog_d;
            ack_q          <= ack_d;
            data_out_q     <= data_out_d;
        end
    end

    assign bus.data_m_ack      = ack_q;
    assign bus.data_m_data_out = data_out_q;
    assign intr_out            = intr_q;
endmodule

// File: tb/tb_pit_timer0.sv
// Bench for pit_timer0: random tick/read traffic against a period-arithmetic model of OUT and the count.
module tb_pit_timer0;
    logic clk = 1'b0;
    logic reset, pit_clk_en, intr_out;
    pit_timer0_if bus();

    pit_timer0 #(.DEFAULT_RELOAD(16'd4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .pit_clk_en(pit_clk_en), .intr_out(intr_out)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // model: mode, effective N, ticks since load, pending load and its N, read toggle
    int m_mode, m_n, m_pn, m_j;
    bit m_pend, m_loaded, m_rtog;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int n_eff(input int raw);
        int n;
        n = (raw == 0) ? 65536 : raw;
        if (m_mode != 0 && n == 1) n = 2;
        return n;
    endfunction

    function automatic bit exp_intr();
        if (!m_loaded) return (m_mode != 0);
        case (m_mode)
            0:       return m_j >= m_n;
            2:       return (m_j % m_n) != (m_n - 1);
            default: return (m_j % m_n) < ((m_n + 1) / 2);
        endcase
    endfunction

    function automatic logic [15:0] exp_count();
        int c;
        c = (m_mode == 0) ? (m_n - m_j) : (m_n - (m_j % m_n));
        return 16'(c & 32'hFFFF);
    endfunction

    task automatic m_reset();
        m_mode = 3; m_pend = 1; m_pn = 4; m_n = 4; m_loaded = 0; m_j = 0; m_rtog = 0;
    endtask

    task automatic mtick();
        if (m_pend) begin
            m_pend = 0; m_loaded = 1; m_j = 0; m_n = m_pn;
        end else if (m_loaded) begin
            m_j++;
        end
    endtask

    task automatic cyc(input bit tk);
        pit_clk_en = tk;
        @(posedge clk); #1;
        if (tk) mtick();
        bus.cs = 0; bus.data_m_access = 0; bus.data_m_wr_en = 0;
        pit_clk_en = 0;
    endtask

    task automatic bus_op(input logic a, input logic [1:0] bs, input logic we, input logic [15:0] wd,
                          input bit tk, output logic [15:0] rdat);
        bus.cs = 1; bus.data_m_access = 1; bus.data_m_addr = a;
        bus.data_m_bytesel = bs; bus.data_m_wr_en = we; bus.data_m_data_in = wd;
        cyc(tk);
        chk("ack", bus.data_m_ack, 1);
        rdat = bus.data_m_data_out;
    endtask

    task automatic wr_ctl(input logic [7:0] cw, input bit tk);
        logic [15:0] d;
        bus_op(1'b1, 2'b10, 1'b1, {cw, 8'hC3}, tk, d);
    endtask

    task automatic wr_dat(input logic [7:0] b);
        logic [15:0] d;
        bus_op(1'b0, 2'b01, 1'b1, {8'h3C, b}, 1'b0, d);
    endtask

    task automatic run(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            cyc($urandom_range(99) < pct);
            chk("intr", intr_out, exp_intr());
        end
    endtask

    task automatic set_mode(input logic [7:0] cw);
        wr_ctl(cw, 1'($urandom_range(1)));
        case (cw[3:1])
            3'd2, 3'd6: m_mode = 2;
            3'd3, 3'd7: m_mode = 3;
            default:    m_mode = 0;
        endcase
        m_pend = 0; m_loaded = 0; m_rtog = 0;
        chk("ctl_intr", intr_out, exp_intr());
    endtask

    task automatic load_n(input int raw);
        wr_dat(raw[7:0]);
        if (m_mode == 0) m_loaded = 0;
        chk("byte1_intr", intr_out, exp_intr());
        wr_dat(raw[15:8]);
        m_pend = 1; m_pn = n_eff(raw);
    endtask

    task automatic rd_cnt(input bit tk);
        logic [15:0] e, d;
        e = exp_count();
        bus_op(1'b0, 2'b11, 1'b0, 16'h0000, tk, d);
        chk(m_rtog ? "rd_msb" : "rd_lsb", d, {8'h00, m_rtog ? e[15:8] : e[7:0]});
        m_rtog = ~m_rtog;
    endtask

    task automatic rd_lat(input logic [15:0] lat);
        logic [15:0] d;
        bus_op(1'b0, 2'b11, 1'b0, 16'h0000, 1'b1, d);
        chk("rd_latch", d, {8'h00, m_rtog ? lat[15:8] : lat[7:0]});
        m_rtog = ~m_rtog;
    endtask

    initial begin
        logic [15:0] lat, d;
        logic [7:0]  cw;
        int raw;
        reset = 1; pit_clk_en = 0;
        bus.cs = 0; bus.data_m_access = 0; bus.data_m_wr_en = 0; bus.data_m_addr = 0;
        bus.data_m_bytesel = 0; bus.data_m_data_in = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_intr", intr_out, 1);
        chk("rst_ack", bus.data_m_ack, 0);
        chk("rst_dout", bus.data_m_data_out, 0);
        reset = 0;

        // default reload 4 in mode 3, tick every cycle
        run(16, 100);

        // reset while OUT is low
        for (int i = 0; i < 8 && exp_intr(); i++) run(1, 100);
        chk("pre_rst_low", intr_out, 0);
        reset = 1; #1;
        chk("mid_rst_intr", intr_out, 1);
        @(posedge clk); #1;
        reset = 0; m_reset();
        run(12, 100);

        // mode 2 / mode 3 with N=5
        set_mode(8'h34); load_n(5); run(20, 100);
        set_mode(8'h36); load_n(5); run(25, 100);

        // mode 0 N=3: rises on the 4th tick, then wraps to FFFF
        set_mode(8'h30); load_n(3); run(5, 100);
        rd_cnt(1'b0); rd_cnt(1'b0);

        // latch: captures pre-tick count, held across ticks, released after two reads
        set_mode(8'h34); load_n(1000); run(20, 100);
        lat = exp_count(); wr_ctl(8'h00, 1'b1);
        run(10, 100);
        rd_lat(lat); rd_lat(lat);
        rd_cnt(1'b1); rd_cnt(1'b1);
        lat = exp_count(); wr_ctl(8'h00, 1'b0);
        run(3, 100); wr_ctl(8'h00, 1'b1); run(3, 100);
        rd_lat(lat); rd_lat(lat);

        // writes to counter 1, counter 2 and a non-zero SC control word are ignored
        bus_op(1'b0, 2'b10, 1'b1, 16'h5A00, 1'b1, d);
        cyc(1'b1); chk("ack_drop1", bus.data_m_ack, 0);
        bus_op(1'b1, 2'b01, 1'b1, 16'h005A, 1'b1, d);
        cyc(1'b1); chk("ack_drop2", bus.data_m_ack, 0);
        bus_op(1'b1, 2'b10, 1'b1, 16'h7400, 1'b1, d);
        cyc(1'b1); chk("ack_drop3", bus.data_m_ack, 0);
        bus_op(1'b0, 2'b10, 1'b0, 16'h0000, 1'b1, d);
        chk("rd_ctr1", d, 0);
        cyc(1'b1); chk("dout_idle", bus.data_m_data_out, 0);
        bus_op(1'b1, 2'b11, 1'b0, 16'h0000, 1'b1, d);
        chk("rd_addr1", d, 0);
        run(30, 100);
        rd_cnt(1'b0); rd_cnt(1'b0);

        // random modes (including aliases and BCD bit), N, tick density and reads
        for (int r = 0; r < 14; r++) begin
            cw  = {2'b00, 2'b11, 3'($urandom_range(7)), 1'($urandom_range(1))};
            set_mode(cw);
            raw = (r < 2) ? r + 1 : $urandom_range(40, 1);
            load_n(raw);
            for (int i = 0; i < 3 * raw + 8; i++) begin
                if (m_mode != 3 && m_loaded && $urandom_range(3) == 0) rd_cnt(1'($urandom_range(1)));
                else run(1, 70);
            end
        end

        // mode 3 with N=0: high for 32768 ticks, then low
        set_mode(8'h36); load_n(0);
        for (int i = 0; i < 32772; i++) begin
            cyc(1'b1);
            if (m_j % 2048 == 0 || m_j >= 32766) chk("m3_n0", intr_out, exp_intr());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pit_timer0.md
Name: pit_timer0

Overview:
- 8254-style programmable interval timer, counter 0 only, on the same 16-bit word bus as the interrupt controller.
- intr_out drives the edge-triggered interrupt controller's intr_in[0]; its rising edges raise IRQ0.
- Counts on a single-cycle clock-enable tick (nominally 1.193182 MHz) from the system clock domain.
- Counters 1/2 decode but do nothing.

Parameters:
DEFAULT_RELOAD  16'h0000  reload value after reset (0 means 65536)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cs  in  1  block select (I/O 0x40-0x43)
data_m_addr  in  1  word select: 0 = 0x40/0x41, 1 = 0x42/0x43
data_m_data_in  in  16  write data
data_m_data_out  out  16  read data, registered
data_m_bytesel  in  2  byte enables
data_m_wr_en  in  1  write strobe
data_m_access  in  1  bus access valid
data_m_ack  out  1  access acknowledge
pit_clk_en  in  1  count tick, one clk wide
intr_out  out  1  counter 0 OUT

Behaviour:
- Reset values:
  - data_m_ack=0, data_m_data_out=0.
  - mode=3, rw=LSB/MSB, reload=DEFAULT_RELOAD, load_pending=1.
  - intr_out=1; latch and toggles cleared.
- Bus timing:
  - data_m_ack registered: 1 the cycle after cs&data_m_access.
  - data_m_data_out registered: read data the cycle after a read access, else 0.
  - Writes take effect at the clock edge of the access.
- Byte map:
  - addr0/byte0: counter 0 data.
  - addr0/byte1: counter 1, writes ignored, reads 0.
  - addr1/byte0: counter 2, writes ignored, reads 0.
  - addr1/byte1: control word, reads 0.
  - Both bytesel bits set: each byte handled independently.
- Control word:
  - [7:6] SC: anything other than 00 is ignored.
  - [5:4] RW: 00 = latch command, 01 = LSB only, 10 = MSB only, 11 = LSB then MSB.
  - [3:1] mode: 0 → mode 0; 2/6 → mode 2; 3/7 → mode 3; 1/4/5 → mode 0.
  - [0] BCD ignored; counting is binary only.
- Control write with RW≠00:
  - Sets rw and mode; clears write/read toggles and the latch.
  - Stops counting (armed=0, load_pending=0).
  - intr_out ← 0 in mode 0, 1 in modes 2/3.
- Latch command:
  - If no latch outstanding, latched ← current count[15:0].
  - Reads return the latched value until fully read per rw, then the latch is released.
  - Latch while already latched is ignored.
- Data write:
  - LSB only: reload={00,d}.
  - MSB only: reload={d,00}.
  - LSB/MSB: first write sets low byte and toggle; second write sets high byte and completes.
  - Completion sets load_pending.
  - Mode 0: the first byte also stops counting and drives intr_out ← 0.
- Read (no latch): live count, byte order per rw, separate read toggle. A count of 65536 reads 0000.
- Counter width: 17-bit internal count. Reload 0 = 65536. Reload 1 in modes 2/3 is treated as 2.
- Load on tick:
  - On a pit_clk_en with load_pending: load count, set armed, clear load_pending; no decrement that tick.
  - Mode 3 loads the high-phase value.
- Mode 0, per armed tick:
  - count−1, wrapping 0→FFFF.
  - On the tick where count goes 1→0, intr_out ← 1; it stays 1 until a control write or new count.
- Mode 2, per armed tick:
  - If count==1: count←reload, intr_out←1.
  - Else count−1, with intr_out←0 when the new count is 1.
  - Net effect: intr_out low for exactly one tick per N-tick period.
- Mode 3, per armed tick:
  - Count decrements by 2.
  - On the tick where count==2: toggle intr_out and load the next phase value.
  - High phase loads N rounded up to even; low phase loads N rounded down to even.
  - Result: high N/2 ticks and low N/2 ticks for even N; high (N+1)/2 and low (N−1)/2 for odd N.
  - A reload written while running takes effect at the next phase load.
- Simultaneous events:
  - Control write and tick in the same cycle: the write wins, the tick is ignored.
  - Count-completing write and tick in the same cycle: the tick acts on the old state; the load happens on the next tick.
  - Latch command and tick in the same cycle: latches the pre-tick count.
- Reset asserted mid-operation returns every register to its reset value immediately.

Test Plan:
- Reset with DEFAULT_RELOAD=4, tick every cycle → intr_out high 2 ticks, low 2 ticks, repeating; first load on tick 1.
- Control 0x34, write 0x05 then 0x00 → mode 2, N=5: intr_out low exactly 1 tick every 5 ticks.
- Control 0x36, N=5 → mode 3: high 3 ticks, low 2 ticks; N=0 → period 65536 ticks.
- Control 0x30, N=3 → intr_out 0 immediately, rises on the 4th tick (load + 3 decrements), stays high; count wraps to FFFF.
- Counting, write 0x00 (latch) to 0x43, wait 10 ticks, read 0x40 twice → returns the pre-wait count LSB then MSB; a third read shows the live count.
- Write 0x5A to 0x41 and 0x42, and control 0x74 → no effect; reads return 0; data_m_ack pulses 1 cycle after each access.
